uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   CPU-side register bus for the UART receive FIFO.
//   sel     : device selected (address decode done outside)
//   addr    : word offset (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   rd_en   : bus read strobe; a DATA read with data present pops one byte
//   wr_en   : bus write strobe
//   wr_data : bus write data
//   rd_data : combinational read data
//   irq     : level interrupt toward the core's external-interrupt input
interface uart_rx_fifo_if;
  logic        sel;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  // Bus master (CPU side)
  modport master (
    output sel, addr, rd_en, wr_en, wr_data,
    input  rd_data, irq
  );

  // Peripheral side
  modport slave (
    input  sel, addr, rd_en, wr_en, wr_data,
    output rd_data, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer between the UART receiver and the CPU bus. Every byte the
//   receiver flags with a one-cycle rx_data_fresh pulse is queued into a
//   DEPTH-entry FIFO. The CPU sees DATA / STATUS / CTRL registers and a level
//   interrupt driven purely from registered state.
//
//   Ports:
//     clk           : CPU clock
//     rst           : asynchronous, active-low reset
//     rx_data       : byte from the UART receiver
//     rx_data_fresh : one-cycle push strobe
//     bus           : register bus (uart_rx_fifo_if.slave)
//
//   Register map (word offsets):
//     0 DATA   : read pops; empty reads 0x100 (bit8 = empty); writes ignored
//     1 STATUS : [0] not_empty [1] full [2] ovf [3] irq [16:8] count;
//                write bit2=1 clears ovf
//     2 CTRL   : [0] ie [1] oie [15:8] thr; write bit2=1 flushes the FIFO
//     3        : reserved, reads 0
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_fresh,
  uart_rx_fifo_if.slave      bus
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [8:0]  DEPTH_W    = 9'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // Storage is deliberately not reset; it is never observed while count=0.
  logic [7:0]  mem [DEPTH];

  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW-1:0] rptr_reg, rptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          ie_reg, ie_next;
  logic          oie_reg, oie_next;
  logic [7:0]    thr_reg, thr_next;

  // Bus decode
  logic rd_data_sel;
  logic wr_status;
  logic wr_ctrl;
  logic flush;
  logic ovf_clr;

  // FIFO control
  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push_drop;

  // Interrupt
  logic [8:0] count_w;
  logic [8:0] thr_eff;
  logic       irq_level;

  assign rd_data_sel = bus.sel & bus.rd_en & (bus.addr == ADDR_DATA);
  assign wr_status   = bus.sel & bus.wr_en & (bus.addr == ADDR_STATUS);
  assign wr_ctrl     = bus.sel & bus.wr_en & (bus.addr == ADDR_CTRL);
  assign flush       = wr_ctrl & bus.wr_data[2];
  assign ovf_clr     = wr_status & bus.wr_data[2];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  assign pop = rd_data_sel & ~empty;

  // A full FIFO still accepts a byte if a pop frees a slot in the same cycle.
  // A flush discards the incoming byte silently: it is neither stored nor
  // counted as an overflow.
  assign push_ok   = rx_data_fresh & (~full | pop) & ~flush;
  assign push_drop = rx_data_fresh & full & ~pop & ~flush;

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    ie_next    = ie_reg;
    oie_next   = oie_reg;
    thr_next   = thr_reg;

    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (push_ok) begin
        wptr_next = wptr_reg + AW'(1);
      end
      if (pop) begin
        rptr_next = rptr_reg + AW'(1);
      end
      count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (push_drop) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end

    if (wr_ctrl) begin
      ie_next  = bus.wr_data[0];
      oie_next = bus.wr_data[1];
      thr_next = bus.wr_data[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      ie_reg    <= 1'b0;
      oie_reg   <= 1'b0;
      thr_reg   <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      ie_reg    <= ie_next;
      oie_reg   <= oie_next;
      thr_reg   <= thr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg] <= rx_data;
    end
  end

  // Threshold of 0 behaves as 1; thresholds beyond DEPTH saturate at DEPTH
  // so a large value can still fire once the FIFO fills.
  assign count_w = 9'(count_reg);

  always_comb begin
    thr_eff = {1'b0, thr_reg};
    if (thr_reg == '0) begin
      thr_eff = 9'd1;
    end else if ({1'b0, thr_reg} > DEPTH_W) begin
      thr_eff = DEPTH_W;
    end
  end

  // Built only from registers, so it changes the cycle after the push/pop
  // that moves count across the threshold and never follows the bus.
  assign irq_level = (ie_reg & (count_w >= thr_eff)) | (oie_reg & ovf_reg);
  assign bus.irq   = irq_level;

  always_comb begin
    bus.rd_data = '0;
    if (bus.sel) begin
      case (bus.addr)
        ADDR_DATA: begin
          if (empty) begin
            bus.rd_data = 32'h0000_0100;
          end else begin
            bus.rd_data[7:0] = mem[rptr_reg];
          end
        end
        ADDR_STATUS: begin
          bus.rd_data[0]    = ~empty;
          bus.rd_data[1]    = full;
          bus.rd_data[2]    = ovf_reg;
          bus.rd_data[3]    = irq_level;
          bus.rd_data[16:8] = count_w;
        end
        ADDR_CTRL: begin
          bus.rd_data[0]    = ie_reg;
          bus.rd_data[1]    = oie_reg;
          bus.rd_data[15:8] = thr_reg;
        end
        default: bus.rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_fresh;
  int         checks;
  int         errors;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_fresh (rx_data_fresh),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s %08h", tag, got);
    end
  endtask

  task automatic idle_bus;
    bus.sel     = 1'b0;
    bus.addr    = 2'd0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'h0;
  endtask

  // All tasks start and end at posedge+1.
  task automatic push_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_fresh = 1'b1;
    @(posedge clk); #1;
    rx_data_fresh = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel   = 1'b1;
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1;
    d = bus.rd_data;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel     = 1'b1;
    bus.addr    = a;
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  logic [31:0] d;
  logic [7:0]  b;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    rx_data       = 8'h00;
    rx_data_fresh = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    check("rst_irq", 32'(bus.irq), 32'h0);
    bus_read(2'd1, d); check("rst_status", d, 32'h0);
    bus_read(2'd2, d); check("rst_ctrl", d, 32'h0);

    // Basic push / pop
    push_byte(8'h41);
    push_byte(8'h42);
    bus_read(2'd1, d); check("status_2", d, 32'h0000_0201);
    bus_read(2'd3, d); check("reserved_rd", d, 32'h0);
    bus.addr = 2'd0; bus.rd_en = 1'b1; bus.sel = 1'b0; #1;
    check("unsel_rd", bus.rd_data, 32'h0);
    @(posedge clk); #1; idle_bus();
    bus_read(2'd0, d); check("data_41", d, 32'h41);
    bus_read(2'd0, d); check("data_42", d, 32'h42);
    bus_read(2'd0, d); check("data_empty", d, 32'h100);
    bus_read(2'd1, d); check("status_0", d, 32'h0);

    // Threshold interrupt: ie=1, thr=4
    bus_write(2'd2, 32'h0000_0401);
    bus_read(2'd2, d); check("ctrl_thr4", d, 32'h0000_0401);
    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i));
    check("irq_below", 32'(bus.irq), 32'h0);
    push_byte(8'h13);
    check("irq_at_thr", 32'(bus.irq), 32'h1);
    bus_read(2'd0, d); check("thr_pop", d, 32'h10);
    check("irq_after_pop", 32'(bus.irq), 32'h0);
    bus_write(2'd2, 32'h0);
    for (int i = 1; i < 4; i++) begin
      bus_read(2'd0, d); check("thr_drain", d, 32'h10 + 32'(i));
    end

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_read(2'd1, d); check("status_ovf", d, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, d); check("ovf_drain", d, 32'(i));
    end
    bus_read(2'd1, d); check("status_ovf_empty", d, 32'h4);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, d); check("status_ovf_clr", d, 32'h0);

    // Full FIFO, push and pop in the same cycle
    for (int i = 0; i < 16; i++) push_byte(8'hB0 + 8'(i));
    rx_data = 8'hAA; rx_data_fresh = 1'b1;
    bus.sel = 1'b1; bus.addr = 2'd0; bus.rd_en = 1'b1; #1;
    check("full_pp_data", bus.rd_data, 32'hB0);
    @(posedge clk); #1; rx_data_fresh = 1'b0; idle_bus();
    bus_read(2'd1, d); check("full_pp_status", d, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      bus_read(2'd0, d); check("full_pp_drain", d, 32'hB0 + 32'(i));
    end
    bus_read(2'd0, d); check("full_pp_last", d, 32'hAA);

    // Flush with a coincident push
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    rx_data = 8'h99; rx_data_fresh = 1'b1;
    bus.sel = 1'b1; bus.addr = 2'd2; bus.wr_en = 1'b1; bus.wr_data = 32'h4;
    @(posedge clk); #1; rx_data_fresh = 1'b0; idle_bus();
    bus_read(2'd1, d); check("flush_status", d, 32'h0);
    bus_read(2'd0, d); check("flush_data", d, 32'h100);
    bus_read(2'd2, d); check("flush_ctrl", d, 32'h0);

    // Pointer wrap: 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      b = 8'((i * 37 + 5) & 255);
      push_byte(b);
      bus_read(2'd0, d); check("wrap", d, {24'h0, b});
    end

    // Asynchronous reset mid-stream
    bus_write(2'd2, 32'h0000_0001);
    for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
    bus_read(2'd1, d); check("pre_rst_status", d, 32'h0000_0709);
    check("pre_rst_irq", 32'(bus.irq), 32'h1);
    #1 rst = 1'b0;
    #1 check("async_rst_irq", 32'(bus.irq), 32'h0);
    bus.sel = 1'b1; bus.addr = 2'd1; #1;
    check("async_rst_status", bus.rd_data, 32'h0);
    bus.addr = 2'd2; #1;
    check("async_rst_ctrl", bus.rd_data, 32'h0);
    idle_bus();
    @(posedge clk); #1 rst = 1'b1;
    bus_read(2'd0, d); check("post_rst_data", d, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
